wb_rr_master_arbiter: RTL and testbench
=======================================

// Module: wb_rr_master_arbiter
// PURPOSE
//  Round-robin Wishbone (pipelined, B4) arbiter: shares one slave-side bus (the data-port interconnect feeding
//  memory port 1, mtime regs, debug IF) between NUM_MASTERS masters (core data port, loader/DMA, debug).
//  Grant is held for the whole cyc; outstanding requests are limited; a watchdog aborts hung cycles with err.
// PARAMETERS
//  NUM_MASTERS      2    number of requesting masters (2..8)
//  MAX_OUTSTANDING  2    max accepted-but-unacknowledged requests per grant (1..15)
//  TIMEOUT_CYCLES   255  cycles with outstanding>0 and no ack/err before abort (>=2)
// PORTS
//  wb_clk_i     in   1        clock
//  wb_rst_i     in   1        reset, asynchronous, active-high
//  m_cyc_i      in   N        per-master cyc
//  m_stb_i      in   N        per-master stb
//  m_we_i       in   N        per-master we
//  m_adr_i      in   32*N     per-master address, master k at [32k+31:32k]
//  m_dat_i      in   32*N     per-master write data
//  m_sel_i      in   4*N      per-master byte select
//  m_stall_o    out  N        stall to each master
//  m_ack_o      out  N        ack to each master
//  m_err_o      out  N        err to each master
//  m_dat_o      out  32*N     read data to each master
//  s_cyc_o      out  1        cyc to slave bus
//  s_stb_o      out  1        stb to slave bus
//  s_we_o/s_adr_o/s_dat_o/s_sel_o  out 1/32/32/4  muxed from granted master
//  s_stall_i/s_ack_i/s_err_i  in 1 each  slave response
//  s_dat_i      in   32       slave read data
//  grant_o      out  N        one-hot registered grant (0 = bus idle)
//  timeout_o    out  1        one-cycle pulse on watchdog abort
// BEHAVIOUR
//  - Reset: grant_o=0, rr pointer=N-1 (master 0 wins first), outstanding=0, timer=0, timeout_o=0;
//    all outputs 0 except m_stall_o = all-ones.
//  - Arbitration only when grant_o==0: winner = first requesting m_cyc_i scanning from pointer+1 (mod N);
//    grant_o and pointer load on that edge. 1 cycle grant latency; requester sees stall=1 meanwhile.
//  - Hold: grant kept while owner's m_cyc_i=1. Owner drops cyc -> grant_o=0 next edge; re-arbitration
//    the following cycle (1 idle cycle between owners, even if same master re-requests).
//  - Slave side: s_cyc_o = owner m_cyc_i & ~abort; s_stb_o = owner m_stb_i & ~limit; other s_* muxed from
//    owner; all s_* = 0 when grant_o==0.
//  - Owner: m_stall_o = s_stall_i | limit; m_ack_o = s_ack_i; m_err_o = s_err_i | timeout_o;
//    m_dat_o = s_dat_i. Non-owners: stall=1, ack=err=0, dat=0.
//  - limit = (outstanding==MAX_OUTSTANDING). Accept = s_stb_o & ~s_stall_i: +1; ack|err: -1;
//    both same cycle: unchanged. Never under/overflows; ack with outstanding==0 is forwarded, count stays 0.
//  - Watchdog: timer clears on accept, ack, err or outstanding==0; else increments. At
//    timer==TIMEOUT_CYCLES-1: timeout_o=1 one cycle, m_err_o to owner same cycle, outstanding<=0,
//    abort forces s_cyc_o=0 that cycle; grant kept until owner drops cyc.
//  - Owner drops cyc with outstanding>0: outstanding and timer clear; late slave acks dropped (no owner).
//  - Async reset mid-cycle: all state cleared immediately; no acks delivered after reset asserts.
// STRUCTURE
//  - Shared header wb_defs.vh: WB_ADR_W=32, WB_DAT_W=32, WB_SEL_W=4 (also used by interconnect/peripherals).
//  - Sub-module rr_arbiter #(N): combinational one-hot round-robin picker (req, pointer -> gnt).
//  - Top: grant/pointer regs, outstanding counter, watchdog timer, muxes.
// TESTING
//  1 Reset: after release, grant_o=0, m_stall_o=2'b11, s_cyc_o=0.
//  2 Both masters assert cyc at T0 -> grant_o=2'b01 at T1; m0 drops at T5 -> grant_o=0 at T6,
//    grant_o=2'b10 at T7.
//  3 m0 single read 0x0001_0004, slave acks next cycle with 0xDEADBEEF -> m_ack_o[0]=1,
//    m_dat_o[31:0]=0xDEADBEEF; m_dat_o[63:32]=0.
//  4 MAX_OUTSTANDING=2, s_stall_i=0, no acks: m0 issues 3 stb -> 2 accepted, m_stall_o[0]=1 on third
//    until first ack, then accepted.
//  5 TIMEOUT_CYCLES=8, slave never acks after accept -> timeout_o and m_err_o[0] 8 cycles later,
//    s_cyc_o=0 that cycle, outstanding=0.
//  6 wb_rst_i asserted with 1 outstanding -> grant_o=0 immediately; late s_ack_i not forwarded.

Source files
------------

// File: rtl/wb_rr_master_arbiter_pkg.sv
// Shared Wishbone bus widths, the owner request bundle and the outstanding-counter step helper
// used by the round-robin master arbiter.
package wb_rr_master_arbiter_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;
    localparam int OUT_W    = 4;

    typedef struct packed {
        logic                we;
        logic [WB_ADR_W-1:0] adr;
        logic [WB_DAT_W-1:0] dat;
        logic [WB_SEL_W-1:0] sel;
    } wb_req_t;

    typedef enum logic [1:0] {
        OUT_HOLD = 2'd0,
        OUT_INC  = 2'd1,
        OUT_DEC  = 2'd2,
        OUT_CLR  = 2'd3
    } out_op_e;

    // Saturating in both directions so the count can never wrap.
    function automatic logic [OUT_W-1:0] out_step(input out_op_e op, input logic [OUT_W-1:0] cnt);
        logic [OUT_W-1:0] res;
        case (op)
            OUT_INC: res = (cnt == 4'hF) ? cnt : cnt + 4'd1;
            OUT_DEC: res = (cnt == 4'h0) ? cnt : cnt - 4'd1;
            OUT_CLR: res = 4'h0;
            default: res = cnt;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/wb_rr_master_arbiter_rr_arbiter.sv
// Combinational one-hot round-robin picker: the first requester after ptr (mod N) wins.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx
);

    // Scan positions ptr+1 .. ptr+N and latch the first request seen.
    always_comb begin : pick
        logic found_s;
        logic hit_s;
        gnt     = '0;
        gnt_idx = '0;
        found_s = 1'b0;
        hit_s   = 1'b0;
        for (int i = 1; i <= N; i++) begin
            for (int j = 0; j < N; j++) begin
                hit_s   = req[j] & ~found_s & (j == ((int'(ptr) + i) % N));
                gnt[j]  = gnt[j] | hit_s;
                gnt_idx = hit_s ? PW'(j) : gnt_idx;
                found_s = found_s | hit_s;
            end
        end
    end

endmodule

// File: rtl/wb_rr_master_arbiter.sv
// Round-robin pipelined Wishbone master arbiter: grant held for a whole cycle, outstanding
// requests capped, watchdog aborts a hung cycle with err to the owner.
module wb_rr_master_arbiter
    import wb_rr_master_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS     = 2,
    parameter int MAX_OUTSTANDING = 2,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                            wb_clk_i,
    input  logic                            wb_rst_i,
    input  logic [NUM_MASTERS-1:0]          m_cyc_i,
    input  logic [NUM_MASTERS-1:0]          m_stb_i,
    input  logic [NUM_MASTERS-1:0]          m_we_i,
    input  logic [WB_ADR_W*NUM_MASTERS-1:0] m_adr_i,
    input  logic [WB_DAT_W*NUM_MASTERS-1:0] m_dat_i,
    input  logic [WB_SEL_W*NUM_MASTERS-1:0] m_sel_i,
    output logic [NUM_MASTERS-1:0]          m_stall_o,
    output logic [NUM_MASTERS-1:0]          m_ack_o,
    output logic [NUM_MASTERS-1:0]          m_err_o,
    output logic [WB_DAT_W*NUM_MASTERS-1:0] m_dat_o,
    output logic                            s_cyc_o,
    output logic                            s_stb_o,
    output logic                            s_we_o,
    output logic [WB_ADR_W-1:0]             s_adr_o,
    output logic [WB_DAT_W-1:0]             s_dat_o,
    output logic [WB_SEL_W-1:0]             s_sel_o,
    input  logic                            s_stall_i,
    input  logic                            s_ack_i,
    input  logic                            s_err_i,
    input  logic [WB_DAT_W-1:0]             s_dat_i,
    output logic [NUM_MASTERS-1:0]          grant_o,
    output logic                            timeout_o
);

    localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [NUM_MASTERS-1:0] grant_r;
    logic [PW-1:0]          ptr_r;
    logic [OUT_W-1:0]       out_r;
    logic [TW-1:0]          timer_r;

    logic [NUM_MASTERS-1:0] arb_gnt_s;
    logic [PW-1:0]          arb_idx_s;
    logic [NUM_MASTERS-1:0] grant_nxt_s;
    logic [PW-1:0]          ptr_nxt_s;
    logic [OUT_W-1:0]       out_nxt_s;
    logic [TW-1:0]          timer_nxt_s;
    out_op_e                out_op_s;
    wb_req_t                own_req_s;
    logic                   busy_s;
    logic                   own_cyc_s;
    logic                   own_stb_s;
    logic                   limit_s;
    logic                   resp_s;
    logic                   dec_s;
    logic                   abort_s;
    logic                   accept_s;

    rr_arbiter #(
        .N  (NUM_MASTERS),
        .PW (PW)
    ) u_rr (
        .req     (m_cyc_i),
        .ptr     (ptr_r),
        .gnt     (arb_gnt_s),
        .gnt_idx (arb_idx_s)
    );

    // AND-OR mux of the granted master's request; everything reads zero while idle.
    always_comb begin
        own_cyc_s = |(grant_r & m_cyc_i);
        own_stb_s = |(grant_r & m_stb_i);
        own_req_s = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            own_req_s.we  = own_req_s.we  | (m_we_i[k] & grant_r[k]);
            own_req_s.adr = own_req_s.adr | (m_adr_i[k*WB_ADR_W +: WB_ADR_W] & {WB_ADR_W{grant_r[k]}});
            own_req_s.dat = own_req_s.dat | (m_dat_i[k*WB_DAT_W +: WB_DAT_W] & {WB_DAT_W{grant_r[k]}});
            own_req_s.sel = own_req_s.sel | (m_sel_i[k*WB_SEL_W +: WB_SEL_W] & {WB_SEL_W{grant_r[k]}});
        end
    end

    assign busy_s   = |grant_r;
    assign limit_s  = busy_s & (out_r == OUT_W'(MAX_OUTSTANDING));
    assign resp_s   = s_ack_i | s_err_i;
    assign dec_s    = resp_s & (out_r != 4'h0);
    // A response arriving on the final watchdog cycle still counts as progress.
    assign abort_s  = own_cyc_s & (out_r != 4'h0) & (timer_r == TW'(TIMEOUT_CYCLES - 1)) & ~resp_s;
    assign accept_s = s_cyc_o & s_stb_o & ~s_stall_i;

    assign s_cyc_o   = own_cyc_s & ~abort_s;
    assign s_stb_o   = own_stb_s & ~limit_s;
    assign s_we_o    = own_req_s.we;
    assign s_adr_o   = own_req_s.adr;
    assign s_dat_o   = own_req_s.dat;
    assign s_sel_o   = own_req_s.sel;
    assign grant_o   = grant_r;
    assign timeout_o = abort_s;

    // Responses route only to the owner; non-owners see a permanently stalled, silent bus.
    always_comb begin
        m_stall_o = '1;
        m_ack_o   = '0;
        m_err_o   = '0;
        m_dat_o   = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            m_stall_o[k] = ~grant_r[k] | s_stall_i | limit_s;
            m_ack_o[k]   = grant_r[k] & s_ack_i;
            m_err_o[k]   = grant_r[k] & (s_err_i | abort_s);
            m_dat_o[k*WB_DAT_W +: WB_DAT_W] = s_dat_i & {WB_DAT_W{grant_r[k]}};
        end
    end

    // Next grant/pointer, outstanding count and watchdog timer.
    always_comb begin
        grant_nxt_s = grant_r;
        ptr_nxt_s   = ptr_r;
        out_op_s    = OUT_HOLD;
        timer_nxt_s = timer_r;

        if (!busy_s) begin
            grant_nxt_s = arb_gnt_s;
            ptr_nxt_s   = (|m_cyc_i) ? arb_idx_s : ptr_r;
        end else if (!own_cyc_s) begin
            grant_nxt_s = '0;
        end else begin
            grant_nxt_s = grant_r;
        end

        if (!own_cyc_s || abort_s) begin
            out_op_s = OUT_CLR;
        end else if (accept_s && !dec_s) begin
            out_op_s = OUT_INC;
        end else if (!accept_s && dec_s) begin
            out_op_s = OUT_DEC;
        end else begin
            out_op_s = OUT_HOLD;
        end

        if (!own_cyc_s || abort_s || accept_s || resp_s || (out_r == 4'h0)) begin
            timer_nxt_s = '0;
        end else begin
            timer_nxt_s = timer_r + TW'(1'b1);
        end
    end

    assign out_nxt_s = out_step(out_op_s, out_r);

    // State registers; the pointer starts at the last master so master 0 wins first.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            grant_r <= '0;
            ptr_r   <= PW'(NUM_MASTERS - 1);
            out_r   <= 4'h0;
            timer_r <= '0;
        end else begin
            grant_r <= grant_nxt_s;
            ptr_r   <= ptr_nxt_s;
            out_r   <= out_nxt_s;
            timer_r <= timer_nxt_s;
        end
    end

endmodule

// File: tb/tb_wb_rr_master_arbiter.sv
// Directed self-checking bench for wb_rr_master_arbiter (2 masters, 2 outstanding, 8-cycle watchdog).
module tb_wb_rr_master_arbiter;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic [1:0]  m_cyc_i, m_stb_i, m_we_i;
    logic [63:0] m_adr_i, m_dat_i;
    logic [7:0]  m_sel_i;
    logic [1:0]  m_stall_o, m_ack_o, m_err_o;
    logic [63:0] m_dat_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic        s_stall_i, s_ack_i, s_err_i;
    logic [31:0] s_dat_i;
    logic [1:0]  grant_o;
    logic        timeout_o;

    int n_pass  = 0;
    int n_total = 0;

    wb_rr_master_arbiter #(
        .NUM_MASTERS     (2),
        .MAX_OUTSTANDING (2),
        .TIMEOUT_CYCLES  (8)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .m_cyc_i   (m_cyc_i),
        .m_stb_i   (m_stb_i),
        .m_we_i    (m_we_i),
        .m_adr_i   (m_adr_i),
        .m_dat_i   (m_dat_i),
        .m_sel_i   (m_sel_i),
        .m_stall_o (m_stall_o),
        .m_ack_o   (m_ack_o),
        .m_err_o   (m_err_o),
        .m_dat_o   (m_dat_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_sel_o   (s_sel_o),
        .s_stall_i (s_stall_i),
        .s_ack_i   (s_ack_i),
        .s_err_i   (s_err_i),
        .s_dat_i   (s_dat_i),
        .grant_o   (grant_o),
        .timeout_o (timeout_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Inputs change on the falling edge; outputs are checked 1 ns later.
    task automatic step();
        @(negedge wb_clk_i);
    endtask

    task automatic clear_inputs();
        m_cyc_i = 2'b00; m_stb_i = 2'b00; m_we_i = 2'b00;
        m_adr_i = 64'h0; m_dat_i = 64'h0; m_sel_i = 8'h00;
        s_stall_i = 1'b0; s_ack_i = 1'b0; s_err_i = 1'b0; s_dat_i = 32'h0;
    endtask

    task automatic test_reset();
        clear_inputs();
        wb_rst_i = 1'b1;
        step(); step();
        wb_rst_i = 1'b0;
        #1;
        n_total++; if (grant_o !== 2'b00) $display("FAIL rst_grant got %b want 00", grant_o); else n_pass++;
        n_total++; if (m_stall_o !== 2'b11) $display("FAIL rst_stall got %b want 11", m_stall_o); else n_pass++;
        n_total++; if (s_cyc_o !== 1'b0) $display("FAIL rst_s_cyc got %b want 0", s_cyc_o); else n_pass++;
        n_total++; if (timeout_o !== 1'b0) $display("FAIL rst_timeout got %b want 0", timeout_o); else n_pass++;
    endtask

    task automatic test_arbitration();
        step(); m_cyc_i = 2'b11; #1;
        n_total++; if (grant_o !== 2'b00) $display("FAIL arb_t0_grant got %b want 00", grant_o); else n_pass++;
        step(); #1;
        n_total++; if (grant_o !== 2'b01) $display("FAIL arb_t1_grant got %b want 01", grant_o); else n_pass++;
        n_total++; if (m_stall_o !== 2'b10) $display("FAIL arb_t1_stall got %b want 10", m_stall_o); else n_pass++;
        n_total++; if (s_cyc_o !== 1'b1) $display("FAIL arb_t1_s_cyc got %b want 1", s_cyc_o); else n_pass++;
        step(); step(); step();
        step(); m_cyc_i = 2'b10; #1;
        n_total++; if (grant_o !== 2'b01) $display("FAIL arb_t5_grant got %b want 01", grant_o); else n_pass++;
        n_total++; if (s_cyc_o !== 1'b0) $display("FAIL arb_t5_s_cyc got %b want 0", s_cyc_o); else n_pass++;
        step(); #1;
        n_total++; if (grant_o !== 2'b00) $display("FAIL arb_t6_grant got %b want 00", grant_o); else n_pass++;
        step(); #1;
        n_total++; if (grant_o !== 2'b10) $display("FAIL arb_t7_grant got %b want 10", grant_o); else n_pass++;
        n_total++; if (s_cyc_o !== 1'b1) $display("FAIL arb_t7_s_cyc got %b want 1", s_cyc_o); else n_pass++;
        step(); m_cyc_i = 2'b00;
        step(); #1;
        n_total++; if (grant_o !== 2'b00) $display("FAIL arb_release got %b want 00", grant_o); else n_pass++;
    endtask

    task automatic test_single_read();
        step();
        m_cyc_i = 2'b01; m_stb_i = 2'b01; m_we_i = 2'b00;
        m_adr_i[31:0] = 32'h0001_0004; m_adr_i[63:32] = 32'hFFFF_FFFF;
        #1;
        n_total++; if (m_stall_o[0] !== 1'b1) $display("FAIL rd_wait_stall got %b want 1", m_stall_o[0]); else n_pass++;
        step(); #1;
        n_total++; if (grant_o !== 2'b01) $display("FAIL rd_grant got %b want 01", grant_o); else n_pass++;
        n_total++; if (s_stb_o !== 1'b1) $display("FAIL rd_s_stb got %b want 1", s_stb_o); else n_pass++;
        n_total++; if (s_adr_o !== 32'h0001_0004) $display("FAIL rd_s_adr got %h want 00010004", s_adr_o); else n_pass++;
        n_total++; if (m_stall_o[0] !== 1'b0) $display("FAIL rd_stall got %b want 0", m_stall_o[0]); else n_pass++;
        step();
        m_stb_i = 2'b00; s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
        #1;
        n_total++; if (m_ack_o !== 2'b01) $display("FAIL rd_ack got %b want 01", m_ack_o); else n_pass++;
        n_total++; if (m_dat_o[31:0] !== 32'hDEAD_BEEF) $display("FAIL rd_dat0 got %h want deadbeef", m_dat_o[31:0]); else n_pass++;
        n_total++; if (m_dat_o[63:32] !== 32'h0) $display("FAIL rd_dat1 got %h want 00000000", m_dat_o[63:32]); else n_pass++;
        step(); clear_inputs();
        step(); #1;
        n_total++; if (grant_o !== 2'b00) $display("FAIL rd_release got %b want 00", grant_o); else n_pass++;
    endtask

    task automatic test_outstanding();
        step(); m_cyc_i = 2'b01; m_stb_i = 2'b01;
        step(); #1;
        n_total++; if (grant_o !== 2'b01) $display("FAIL os_grant got %b want 01", grant_o); else n_pass++;
        n_total++; if (m_stall_o[0] !== 1'b0) $display("FAIL os_acc1_stall got %b want 0", m_stall_o[0]); else n_pass++;
        step(); #1;
        n_total++; if (m_stall_o[0] !== 1'b0) $display("FAIL os_acc2_stall got %b want 0", m_stall_o[0]); else n_pass++;
        step(); #1;
        n_total++; if (m_stall_o[0] !== 1'b1) $display("FAIL os_limit_stall got %b want 1", m_stall_o[0]); else n_pass++;
        n_total++; if (s_stb_o !== 1'b0) $display("FAIL os_limit_s_stb got %b want 0", s_stb_o); else n_pass++;
        step(); s_ack_i = 1'b1; #1;
        n_total++; if (m_ack_o !== 2'b01) $display("FAIL os_ack got %b want 01", m_ack_o); else n_pass++;
        n_total++; if (m_stall_o[0] !== 1'b1) $display("FAIL os_ack_stall got %b want 1", m_stall_o[0]); else n_pass++;
        step(); s_ack_i = 1'b0; #1;
        n_total++; if (m_stall_o[0] !== 1'b0) $display("FAIL os_acc3_stall got %b want 0", m_stall_o[0]); else n_pass++;
        n_total++; if (s_stb_o !== 1'b1) $display("FAIL os_acc3_s_stb got %b want 1", s_stb_o); else n_pass++;
        step(); m_stb_i = 2'b00; s_ack_i = 1'b1; #1;
        n_total++; if (m_stall_o[0] !== 1'b1) $display("FAIL os_full_again got %b want 1", m_stall_o[0]); else n_pass++;
        step(); #1;
        n_total++; if (m_stall_o[0] !== 1'b0) $display("FAIL os_drain_stall got %b want 0", m_stall_o[0]); else n_pass++;
        step(); clear_inputs();
        step(); #1;
        n_total++; if (grant_o !== 2'b00) $display("FAIL os_release got %b want 00", grant_o); else n_pass++;
    endtask

    task automatic test_timeout();
        step(); m_cyc_i = 2'b01; m_stb_i = 2'b01;
        step(); #1;
        n_total++; if (grant_o !== 2'b01) $display("FAIL to_grant got %b want 01", grant_o); else n_pass++;
        step(); m_stb_i = 2'b00; #1;
        n_total++; if (timeout_o !== 1'b0) $display("FAIL to_early_c2 got %b want 0", timeout_o); else n_pass++;
        for (int c = 3; c <= 8; c++) begin
            step(); #1;
            n_total++; if (timeout_o !== 1'b0) $display("FAIL to_early_c%0d got %b want 0", c, timeout_o); else n_pass++;
        end
        step(); #1;
        n_total++; if (timeout_o !== 1'b1) $display("FAIL to_pulse got %b want 1", timeout_o); else n_pass++;
        n_total++; if (m_err_o !== 2'b01) $display("FAIL to_err got %b want 01", m_err_o); else n_pass++;
        n_total++; if (s_cyc_o !== 1'b0) $display("FAIL to_s_cyc got %b want 0", s_cyc_o); else n_pass++;
        step(); #1;
        n_total++; if (timeout_o !== 1'b0) $display("FAIL to_after got %b want 0", timeout_o); else n_pass++;
        n_total++; if (m_err_o !== 2'b00) $display("FAIL to_after_err got %b want 00", m_err_o); else n_pass++;
        n_total++; if (s_cyc_o !== 1'b1) $display("FAIL to_after_s_cyc got %b want 1", s_cyc_o); else n_pass++;
        n_total++; if (grant_o !== 2'b01) $display("FAIL to_kept_grant got %b want 01", grant_o); else n_pass++;
        n_total++; if (m_stall_o[0] !== 1'b0) $display("FAIL to_cleared_stall got %b want 0", m_stall_o[0]); else n_pass++;
        step(); clear_inputs();
        step(); #1;
        n_total++; if (grant_o !== 2'b00) $display("FAIL to_release got %b want 00", grant_o); else n_pass++;
    endtask

    task automatic test_reset_mid_cycle();
        step(); m_cyc_i = 2'b01; m_stb_i = 2'b01;
        step();
        step(); m_stb_i = 2'b00; #1;
        n_total++; if (grant_o !== 2'b01) $display("FAIL mr_grant got %b want 01", grant_o); else n_pass++;
        #1 wb_rst_i = 1'b1;
        #1;
        n_total++; if (grant_o !== 2'b00) $display("FAIL mr_grant_cleared got %b want 00", grant_o); else n_pass++;
        s_ack_i = 1'b1;
        #1;
        n_total++; if (m_ack_o !== 2'b00) $display("FAIL mr_late_ack got %b want 00", m_ack_o); else n_pass++;
        step(); clear_inputs();
        step(); wb_rst_i = 1'b0; #1;
        n_total++; if (grant_o !== 2'b00) $display("FAIL mr_post_grant got %b want 00", grant_o); else n_pass++;
        n_total++; if (m_stall_o !== 2'b11) $display("FAIL mr_post_stall got %b want 11", m_stall_o); else n_pass++;
    endtask

    task automatic test_back_to_back();
        step(); m_cyc_i = 2'b11;
        step(); #1;
        n_total++; if (grant_o !== 2'b01) $display("FAIL b2b_first got %b want 01", grant_o); else n_pass++;
        step(); m_cyc_i = 2'b10;
        step(); m_cyc_i = 2'b11; #1;
        n_total++; if (grant_o !== 2'b00) $display("FAIL b2b_idle1 got %b want 00", grant_o); else n_pass++;
        step();
        m_we_i = 2'b10; m_dat_i[63:32] = 32'h1234_5678; m_sel_i[7:4] = 4'hA; m_sel_i[3:0] = 4'h5;
        #1;
        n_total++; if (grant_o !== 2'b10) $display("FAIL b2b_second got %b want 10", grant_o); else n_pass++;
        n_total++; if (s_we_o !== 1'b1) $display("FAIL b2b_s_we got %b want 1", s_we_o); else n_pass++;
        n_total++; if (s_dat_o !== 32'h1234_5678) $display("FAIL b2b_s_dat got %h want 12345678", s_dat_o); else n_pass++;
        n_total++; if (s_sel_o !== 4'hA) $display("FAIL b2b_s_sel got %h want a", s_sel_o); else n_pass++;
        n_total++; if (m_stall_o !== 2'b01) $display("FAIL b2b_stall got %b want 01", m_stall_o); else n_pass++;
        step(); m_cyc_i = 2'b01;
        step(); #1;
        n_total++; if (grant_o !== 2'b00) $display("FAIL b2b_idle2 got %b want 00", grant_o); else n_pass++;
        n_total++; if (m_stall_o !== 2'b11) $display("FAIL b2b_idle2_stall got %b want 11", m_stall_o); else n_pass++;
        step(); #1;
        n_total++; if (grant_o !== 2'b01) $display("FAIL b2b_third got %b want 01", grant_o); else n_pass++;
        step(); clear_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_single_read();
        test_outstanding();
        test_timeout();
        test_reset_mid_cycle();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
